// File: rtl/rtc_write_sequencer_if.sv
// Handshake and multiplexed address/data bus between the RTC write sequencer
// and its upstream data mux / downstream RTC.
interface rtc_write_sequencer_if;
    logic       start;
    logic       abort;
    logic [7:0] wr_data;
    logic [3:0] reg_idx;
    logic [7:0] ad_bus;
    logic       ad_sel;
    logic       wr_en;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, wr_data,
        input  reg_idx, ad_bus, ad_sel, wr_en, busy, done
    );

    modport slave (
        input  start, abort, wr_data,
        output reg_idx, ad_bus, ad_sel, wr_en, busy, done
    );
endinterface

// File: rtl/rtc_write_sequencer.sv
// Writes NREG RTC registers over a multiplexed address/data bus, each phase
// held for HOLD+1 clocks; one done pulse per completed sequence.
module rtc_write_sequencer #(
    parameter int unsigned HOLD = 12'h100,
    parameter int unsigned NREG = 11
) (
    input logic                  clk,
    input logic                  reset,
    rtc_write_sequencer_if.slave seq
);
    localparam logic [11:0] HOLD_C   = 12'(HOLD);
    localparam logic [3:0]  LAST_IDX = 4'(NREG - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state;
    logic [11:0] cnt;
    logic [3:0]  idx;
    logic [7:0]  data_q;
    logic [7:0]  addr_q;
    logic        ad_sel_q;
    logic        wr_en_q;
    logic        busy_q;
    logic        done_q;
    logic [8:0]  map_first;
    logic [8:0]  map_next;

    // {valid, address}; unmapped indices leave the bus undriven
    function automatic logic [8:0] addr_map(input logic [3:0] i);
        if (i < 4'd8)
            return {1'b1, 8'h21 + {5'b0, i[2:0]}};
        case (i)
            4'd8:    return {1'b1, 8'h41};
            4'd9:    return {1'b1, 8'h42};
            4'd10:   return {1'b1, 8'h43};
            default: return {1'b0, 8'h00};
        endcase
    endfunction

    always_comb begin
        map_first = addr_map(4'd0);
        map_next  = addr_map(idx + 4'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            ad_sel_q <= 1'b0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (seq.start) begin
                        state             <= ADDR;
                        {wr_en_q, addr_q} <= map_first;
                        ad_sel_q          <= 1'b0;
                        busy_q            <= 1'b1;
                    end
                end
                ADDR: begin
                    if (seq.abort) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        idx      <= '0;
                        ad_sel_q <= 1'b0;
                        wr_en_q  <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (cnt == HOLD_C) begin
                        // reg_idx has been stable all phase, so wr_data is settled here
                        state    <= DATA;
                        cnt      <= '0;
                        data_q   <= seq.wr_data;
                        ad_sel_q <= 1'b1;
                        wr_en_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                DATA: begin
                    if (seq.abort) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        idx      <= '0;
                        ad_sel_q <= 1'b0;
                        wr_en_q  <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (cnt == HOLD_C) begin
                        cnt      <= '0;
                        ad_sel_q <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            wr_en_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            state             <= ADDR;
                            idx               <= idx + 4'd1;
                            {wr_en_q, addr_q} <= map_next;
                        end
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    idx      <= '0;
                    ad_sel_q <= 1'b0;
                    wr_en_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign seq.reg_idx = idx;
    assign seq.ad_sel  = ad_sel_q;
    assign seq.wr_en   = wr_en_q;
    assign seq.busy    = busy_q;
    assign seq.done    = done_q;
    assign seq.ad_bus  = wr_en_q ? (ad_sel_q ? data_q : addr_q) : 8'hZZ;

endmodule

// File: doc/rtc_write_sequencer.md
RTC_WRITE_SEQUENCER -- requirements
Module: rtc_write_sequencer

Interface
REQ-001 Parameter HOLD, default 12'h100, sets the last count value of each bus phase; each phase lasts HOLD+1 clk cycles.
REQ-002 Parameter NREG, default 11, is the number of RTC registers written per sequence.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 start  input  1  one-cycle request to begin a write sequence; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of a sequence in progress.
REQ-007 wr_data  input  8  data for the register selected by reg_idx, supplied by an upstream mux.
REQ-008 reg_idx  output  4  index (0..NREG-1) of the register currently being written.
REQ-009 ad_bus  output  8  multiplexed address/data bus; high-Z (8'hZZ) when not driving.
REQ-010 ad_sel  output  1  0 = address phase, 1 = data phase; 0 when idle.
REQ-011 wr_en  output  1  high while ad_bus carries valid address or data.
REQ-012 busy  output  1  high from the first ADDR cycle through the last DATA cycle.
REQ-013 done  output  1  one-cycle pulse when all NREG registers have been written.

Function
REQ-014 States: IDLE, ADDR, DATA, DONE; 12-bit phase counter cnt; 4-bit index idx driving reg_idx.
REQ-015 Address map from idx: 0..7 -> 8'h21..8'h28; 8 -> 8'h41; 9 -> 8'h42; 10 -> 8'h43; any other value -> 8'hZZ with wr_en=0.
REQ-016 IDLE: ad_bus=8'hZZ, ad_sel=0, wr_en=0, busy=0, idx=0, cnt=0; start=1 -> ADDR on the next cycle.
REQ-017 ADDR: ad_bus=address(idx), ad_sel=0, wr_en=1, busy=1; cnt increments each cycle.
REQ-018 ADDR exit: when cnt==HOLD, clear cnt, latch wr_data into data_q in that same cycle, and go to DATA.
REQ-019 DATA: ad_bus=data_q, ad_sel=1, wr_en=1, busy=1; cnt increments each cycle.
REQ-020 DATA exit: when cnt==HOLD, clear cnt; if idx==NREG-1 go to DONE, else increment idx and go to ADDR.
REQ-021 DONE: one cycle with done=1, ad_bus=8'hZZ, wr_en=0, busy=0; then IDLE.
REQ-022 Timing: one register write takes 2*(HOLD+1) cycles; a full sequence is NREG*2*(HOLD+1) busy cycles followed by 1 DONE cycle.
REQ-023 reg_idx is stable for the whole ADDR and DATA phases of a register, so upstream wr_data settles before it is latched.
REQ-024 start while busy or in DONE is ignored and not queued.
REQ-025 abort=1 in ADDR or DATA: next cycle is IDLE, bus high-Z, no done pulse; abort has priority over phase exit.
REQ-026 abort in IDLE or DONE has no effect; a DONE cycle still completes.
REQ-027 start and abort high together in IDLE: start wins, because abort is ignored in IDLE.
REQ-028 cnt never exceeds HOLD, and idx never exceeds NREG-1, while busy.

Reset
REQ-029 reset=1 forces IDLE asynchronously: ad_bus=8'hZZ, ad_sel=0, wr_en=0, busy=0, done=0, reg_idx=0, cnt=0, data_q=8'h00.
REQ-030 Reset asserted mid-sequence aborts the sequence with no done pulse; the first start after reset deassertion begins at idx=0.

Verification (HOLD=4, NREG=11)
REQ-031 Pulse start; drive wr_data=8'h50+reg_idx -> ad_bus goes 8'h21 for 5 cycles (ad_sel=0), then 8'h50 for 5 cycles (ad_sel=1), and so on through 8'h43 then 8'h5A; done pulses at cycle 111 after start.
REQ-032 Change wr_data mid-ADDR for idx=3 -> DATA carries the value present in the last ADDR cycle and stays stable for all 5 DATA cycles.
REQ-033 Pulse start again at cycle 20 of a sequence -> no effect; the sequence and the done timing are unchanged.
REQ-034 Assert abort during DATA of idx=5 -> next cycle is IDLE, ad_bus=8'hZZ, busy=0, no done; a new start writes 8'h21 first.
REQ-035 Assert reset asynchronously mid-ADDR of idx=8 -> outputs go to reset values before the next clk edge; no done pulse.
REQ-036 Hold start high continuously -> sequences run back to back, separated by the 1-cycle DONE state and 1 IDLE cycle.
